// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers.
//   stage_state_e  : occupancy state of a skid-buffered stage (empty / one / two entries)
//   *CtrlW/*DataW  : payload widths used at each inter-stage boundary
//   ex_mem_*_t     : packed views of the EX/MEM payload so both ends pack/unpack identically
//   state_to_occ   : entry count for a given state
package pipe_pkg;

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StBusy  = 2'd1,
      StFull  = 2'd2
   } stage_state_e;

   // EX/MEM control bundle.
   typedef struct packed {
      logic       rd_wren;
      logic [1:0] wb_sel;
      logic       mem_wren;
      logic [2:0] ld_st_sel;
      logic       insn_vld;
   } ex_mem_ctrl_t;

   // EX/MEM data bundle.
   typedef struct packed {
      logic [31:0] alu_data;
      logic [31:0] st_data;
      logic [31:0] pc;
      logic [4:0]  rd;
   } ex_mem_data_t;

   localparam int unsigned IfIdCtrlW  = 1;
   localparam int unsigned IfIdDataW  = 64;
   localparam int unsigned IdExCtrlW  = 12;
   localparam int unsigned IdExDataW  = 128;
   localparam int unsigned ExMemCtrlW = $bits(ex_mem_ctrl_t);
   localparam int unsigned ExMemDataW = $bits(ex_mem_data_t);
   localparam int unsigned MemWbCtrlW = 4;
   localparam int unsigned MemWbDataW = 69;

   function automatic logic [1:0] state_to_occ(input stage_state_e st);
      logic [1:0] occ;
      occ = 2'd0;
      case (st)
         StBusy:  occ = 2'd1;
         StFull:  occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, stall and synchronous flush.
// The payload is split into a control field (cleared on flush, so a flushed slot is a bubble)
// and a data field (cleared on flush only when CLR_DATA = 1).
// With SKID_EN = 1 a second (skid) entry lets o_up_ready come straight from a register
// while still sustaining one transfer per cycle; with SKID_EN = 0 it is a single register
// with combinational ready.
// Ports:
//   i_clk, i_rst_n           clock (rising edge), synchronous active-low reset
//   i_flush                  kill all held entries at the next edge
//   i_up_valid / o_up_ready  upstream handshake, payload i_up_ctrl / i_up_data
//   o_dn_valid / i_dn_ready  downstream handshake, payload o_dn_ctrl / o_dn_data
//   o_occ                    number of entries held (0..2)
module pipe_stage_hs
   import pipe_pkg::*;
#(
   parameter int unsigned CTRL_W   = 8,
   parameter int unsigned DATA_W   = 101,
   parameter bit          SKID_EN  = 1'b1,
   parameter bit          CLR_DATA = 1'b0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_flush,
   input  logic              i_up_valid,
   output logic              o_up_ready,
   input  logic [CTRL_W-1:0] i_up_ctrl,
   input  logic [DATA_W-1:0] i_up_data,
   output logic              o_dn_valid,
   input  logic              i_dn_ready,
   output logic [CTRL_W-1:0] o_dn_ctrl,
   output logic [DATA_W-1:0] o_dn_data,
   output logic [1:0]        o_occ
);

   logic              accept;
   logic              pop;
   logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;

   assign accept = i_up_valid & o_up_ready;
   assign pop    = o_dn_valid & i_dn_ready;

   // Output register: the entry presented downstream.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         out_ctrl_q <= '0;
         out_data_q <= '0;
      end else begin
         out_ctrl_q <= out_ctrl_d;
         out_data_q <= out_data_d;
      end
   end

   assign o_dn_ctrl = out_ctrl_q;
   assign o_dn_data = out_data_q;

   if (SKID_EN) begin : g_skid
      stage_state_e      state_q, state_d;
      logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
      logic [DATA_W-1:0] skid_data_q, skid_data_d;

      always_comb begin
         state_d     = state_q;
         out_ctrl_d  = out_ctrl_q;
         out_data_d  = out_data_q;
         skid_ctrl_d = skid_ctrl_q;
         skid_data_d = skid_data_q;
         if (i_flush) begin
            // Upstream offer is dropped; a same-cycle pop has already been delivered.
            state_d     = StEmpty;
            out_ctrl_d  = '0;
            skid_ctrl_d = '0;
            if (CLR_DATA) begin
               out_data_d  = '0;
               skid_data_d = '0;
            end
         end else begin
            unique case (state_q)
               StEmpty: begin
                  if (accept) begin
                     out_ctrl_d = i_up_ctrl;
                     out_data_d = i_up_data;
                     state_d    = StBusy;
                  end
               end
               StBusy: begin
                  if (accept && pop) begin
                     out_ctrl_d = i_up_ctrl;
                     out_data_d = i_up_data;
                  end else if (accept) begin
                     // Downstream stalled: park the new entry behind the output.
                     skid_ctrl_d = i_up_ctrl;
                     skid_data_d = i_up_data;
                     state_d     = StFull;
                  end else if (pop) begin
                     out_ctrl_d = '0;
                     state_d    = StEmpty;
                  end
               end
               StFull: begin
                  // o_up_ready is low here, so only a pop can happen.
                  if (pop) begin
                     out_ctrl_d  = skid_ctrl_q;
                     out_data_d  = skid_data_q;
                     skid_ctrl_d = '0;
                     state_d     = StBusy;
                  end
               end
               default: begin
                  state_d    = StEmpty;
                  out_ctrl_d = '0;
               end
            endcase
         end
      end

      always_ff @(posedge i_clk) begin
         if (!i_rst_n) begin
            state_q     <= StEmpty;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
         end else begin
            state_q     <= state_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
         end
      end

      assign o_dn_valid = (state_q != StEmpty);
      assign o_up_ready = (state_q != StFull);
      assign o_occ      = state_to_occ(state_q);
   end else begin : g_pass
      logic valid_q, valid_d;

      always_comb begin
         valid_d    = valid_q;
         out_ctrl_d = out_ctrl_q;
         out_data_d = out_data_q;
         if (i_flush) begin
            valid_d    = 1'b0;
            out_ctrl_d = '0;
            if (CLR_DATA) begin
               out_data_d = '0;
            end
         end else if (accept) begin
            valid_d    = 1'b1;
            out_ctrl_d = i_up_ctrl;
            out_data_d = i_up_data;
         end else if (pop) begin
            valid_d    = 1'b0;
            out_ctrl_d = '0;
         end
      end

      always_ff @(posedge i_clk) begin
         if (!i_rst_n) begin
            valid_q <= 1'b0;
         end else begin
            valid_q <= valid_d;
         end
      end

      assign o_dn_valid = valid_q;
      assign o_up_ready = i_dn_ready | ~valid_q;
      assign o_occ      = {1'b0, valid_q};
   end

endmodule

// File: tb/tb_pipe_stage_hs.sv
module tb_pipe_stage_hs;

   localparam int unsigned CW = 8;
   localparam int unsigned DW = 32;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          up_valid;
   logic [CW-1:0] up_ctrl;
   logic [DW-1:0] up_data;
   logic          dn_ready;

   logic          s_up_ready, s_dn_valid;
   logic [CW-1:0] s_dn_ctrl;
   logic [DW-1:0] s_dn_data;
   logic [1:0]    s_occ;
   logic          p_up_ready, p_dn_valid;
   logic [CW-1:0] p_dn_ctrl;
   logic [DW-1:0] p_dn_data;
   logic [1:0]    p_occ;

   // Skid-buffered stage, data kept on flush.
   pipe_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b1), .CLR_DATA(1'b0)) u_skid (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
      .i_up_valid(up_valid), .o_up_ready(s_up_ready), .i_up_ctrl(up_ctrl), .i_up_data(up_data),
      .o_dn_valid(s_dn_valid), .i_dn_ready(dn_ready), .o_dn_ctrl(s_dn_ctrl),
      .o_dn_data(s_dn_data), .o_occ(s_occ)
   );

   // Single-register stage, data cleared on flush.
   pipe_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b0), .CLR_DATA(1'b1)) u_pass (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
      .i_up_valid(up_valid), .o_up_ready(p_up_ready), .i_up_ctrl(up_ctrl), .i_up_data(up_data),
      .o_dn_valid(p_dn_valid), .i_dn_ready(dn_ready), .o_dn_ctrl(p_dn_ctrl),
      .o_dn_data(p_dn_data), .o_occ(p_occ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_err;
   int n_chk;

   // Reference model: each stage is an in-order queue of entries; capacity 2 (skid) or 1.
   typedef struct packed {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          q_s[$];
   ent_t          q_p[$];
   logic [DW-1:0] last_s, last_p;

   typedef struct {
      logic          rst_n, flush, up_valid;
      logic [CW-1:0] up_ctrl;
      logic [DW-1:0] up_data;
      logic          dn_ready;
      logic          exp_valid;
      logic [CW-1:0] exp_ctrl;
      logic [DW-1:0] exp_data;
      logic [1:0]    exp_occ;
      logic          exp_ready;
   } vec_t;

   vec_t vecs[17];

   function automatic vec_t mk(input logic r, input logic f, input logic v,
                               input logic [CW-1:0] c, input logic [DW-1:0] d, input logic rdy,
                               input logic ev, input logic [CW-1:0] ec, input logic [DW-1:0] ed,
                               input logic [1:0] eo, input logic er);
      vec_t t;
      t.rst_n = r; t.flush = f; t.up_valid = v; t.up_ctrl = c; t.up_data = d;
      t.dn_ready = rdy; t.exp_valid = ev; t.exp_ctrl = ec; t.exp_data = ed;
      t.exp_occ = eo; t.exp_ready = er;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_update();
      bit pop, rdy;
      // Skid stage: holds up to two entries, ready while not full.
      if (!rst_n) begin
         q_s.delete();
         last_s = '0;
      end else if (flush) begin
         q_s.delete();
      end else begin
         pop = (q_s.size() > 0) && dn_ready;
         rdy = (q_s.size() < 2);
         if (pop) void'(q_s.pop_front());
         if (up_valid && rdy) q_s.push_back({up_ctrl, up_data});
      end
      if (q_s.size() > 0) last_s = q_s[0].d;
      // Single-register stage: ready if empty or draining this cycle.
      if (!rst_n) begin
         q_p.delete();
         last_p = '0;
      end else if (flush) begin
         q_p.delete();
         last_p = '0;
      end else begin
         pop = (q_p.size() > 0) && dn_ready;
         rdy = dn_ready || (q_p.size() == 0);
         if (pop) void'(q_p.pop_front());
         if (up_valid && rdy) q_p.push_back({up_ctrl, up_data});
      end
      if (q_p.size() > 0) last_p = q_p[0].d;
   endtask

   task automatic compare_models();
      chk("skid_valid", 64'(s_dn_valid), 64'(q_s.size() > 0));
      chk("skid_ctrl", 64'(s_dn_ctrl), (q_s.size() > 0) ? 64'(q_s[0].c) : 64'd0);
      chk("skid_data", 64'(s_dn_data), (q_s.size() > 0) ? 64'(q_s[0].d) : 64'(last_s));
      chk("skid_occ", 64'(s_occ), 64'(q_s.size()));
      chk("skid_ready", 64'(s_up_ready), 64'(q_s.size() < 2));
      chk("pass_valid", 64'(p_dn_valid), 64'(q_p.size() > 0));
      chk("pass_ctrl", 64'(p_dn_ctrl), (q_p.size() > 0) ? 64'(q_p[0].c) : 64'd0);
      chk("pass_data", 64'(p_dn_data), (q_p.size() > 0) ? 64'(q_p[0].d) : 64'(last_p));
      chk("pass_occ", 64'(p_occ), 64'(q_p.size()));
      chk("pass_ready", 64'(p_up_ready), 64'(dn_ready || (q_p.size() == 0)));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      compare_models();
   endtask

   initial begin
      logic [DW-1:0] got[$];
      int            k;
      bit            pre_rdy;

      n_err = 0;
      n_chk = 0;
      last_s = '0;
      last_p = '0;
      rst_n = 1'b0; flush = 1'b0; up_valid = 1'b0; up_ctrl = '0; up_data = '0; dn_ready = 1'b0;

      //            rst flu vld ctrl   data     rdy  ev  ectrl  edata    occ er
      vecs[0]  = mk(0, 0, 0, 8'h00, 32'h0000, 0,   0, 8'h00, 32'h0000, 0, 1);
      vecs[1]  = mk(0, 0, 0, 8'h00, 32'h0000, 0,   0, 8'h00, 32'h0000, 0, 1);
      vecs[2]  = mk(1, 0, 1, 8'h5A, 32'h1234, 1,   1, 8'h5A, 32'h1234, 1, 1);
      vecs[3]  = mk(1, 0, 0, 8'h00, 32'h0000, 1,   0, 8'h00, 32'h1234, 0, 1);
      vecs[4]  = mk(1, 0, 1, 8'h11, 32'h0011, 0,   1, 8'h11, 32'h0011, 1, 1);
      vecs[5]  = mk(1, 0, 1, 8'h22, 32'h0022, 0,   1, 8'h11, 32'h0011, 2, 0);
      vecs[6]  = mk(1, 0, 1, 8'h33, 32'h0033, 0,   1, 8'h11, 32'h0011, 2, 0);
      vecs[7]  = mk(1, 0, 1, 8'h33, 32'h0033, 1,   1, 8'h22, 32'h0022, 1, 1);
      vecs[8]  = mk(1, 0, 1, 8'h33, 32'h0033, 1,   1, 8'h33, 32'h0033, 1, 1);
      vecs[9]  = mk(1, 0, 0, 8'h00, 32'h0000, 1,   0, 8'h00, 32'h0033, 0, 1);
      vecs[10] = mk(1, 0, 1, 8'h44, 32'h0044, 0,   1, 8'h44, 32'h0044, 1, 1);
      vecs[11] = mk(1, 0, 1, 8'h55, 32'h0055, 0,   1, 8'h44, 32'h0044, 2, 0);
      vecs[12] = mk(1, 1, 1, 8'h66, 32'h0066, 0,   0, 8'h00, 32'h0044, 0, 1);
      vecs[13] = mk(1, 0, 0, 8'h00, 32'h0000, 1,   0, 8'h00, 32'h0044, 0, 1);
      vecs[14] = mk(1, 0, 1, 8'h77, 32'h0077, 0,   1, 8'h77, 32'h0077, 1, 1);
      vecs[15] = mk(0, 0, 1, 8'h88, 32'h0088, 0,   0, 8'h00, 32'h0000, 0, 1);
      vecs[16] = mk(1, 0, 0, 8'h00, 32'h0000, 0,   0, 8'h00, 32'h0000, 0, 1);

      for (int i = 0; i < 17; i++) begin
         rst_n = vecs[i].rst_n; flush = vecs[i].flush; up_valid = vecs[i].up_valid;
         up_ctrl = vecs[i].up_ctrl; up_data = vecs[i].up_data; dn_ready = vecs[i].dn_ready;
         step();
         chk($sformatf("vec%0d_valid", i), 64'(s_dn_valid), 64'(vecs[i].exp_valid));
         chk($sformatf("vec%0d_ctrl", i), 64'(s_dn_ctrl), 64'(vecs[i].exp_ctrl));
         chk($sformatf("vec%0d_data", i), 64'(s_dn_data), 64'(vecs[i].exp_data));
         chk($sformatf("vec%0d_occ", i), 64'(s_occ), 64'(vecs[i].exp_occ));
         chk($sformatf("vec%0d_ready", i), 64'(s_up_ready), 64'(vecs[i].exp_ready));
      end

      // Reset glitch between edges must not be seen.
      up_valid = 1'b1; up_ctrl = 8'h99; up_data = 32'h99; dn_ready = 1'b0;
      step();
      up_valid = 1'b0;
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      step();
      chk("glitch_skid_valid", 64'(s_dn_valid), 64'd1);
      chk("glitch_skid_data", 64'(s_dn_data), 64'h99);
      chk("glitch_pass_valid", 64'(p_dn_valid), 64'd1);

      // Stream 1..16 with downstream ready toggling.
      flush = 1'b1;
      step();
      flush = 1'b0;
      k = 1;
      for (int cyc = 0; cyc < 200 && got.size() < 16; cyc++) begin
         dn_ready = (cyc % 2 == 0);
         up_valid = (k <= 16);
         up_ctrl = CW'(k);
         up_data = DW'(k);
         pre_rdy = dn_ready || (q_p.size() == 0);
         if (p_dn_valid && dn_ready) got.push_back(p_dn_data);
         step();
         if (up_valid && pre_rdy) k++;
      end
      chk("stream_count", 64'(got.size()), 64'd16);
      for (int i = 0; i < got.size(); i++) chk($sformatf("stream_item%0d", i), 64'(got[i]), 64'(i + 1));

      // Random traffic, both configurations against the queue model.
      up_valid = 1'b0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         rst_n = ($urandom_range(0, 499) != 0);
         flush = ($urandom_range(0, 63) == 0);
         up_valid = ($urandom_range(0, 3) != 0);
         up_ctrl = CW'($urandom);
         up_data = $urandom;
         dn_ready = (cyc % 1000 < 500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
